// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default frame geometry and
// oversample helpers. Used by both uart_rx and uart_tx.
`timescale 1ns/1ps

package uart_pkg;

    // Default baud_in rising edges per bit period.
    localparam int OVERSAMPLE_DEF = 16;

    // Default payload bits per frame, sent LSB first.
    localparam int DATA_BITS_DEF  = 8;

    // Tick index of the middle of a bit, counted from the start-bit edge.
    function automatic int mid_tick(input int oversample);
        return oversample / 2 - 1;
    endfunction

    localparam int MID_TICK = mid_tick(OVERSAMPLE_DEF);

    // Frame-level state, shared by the receiver and the transmitter.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_edge.sv
// Input conditioning for uart_rx: a multi-flop synchroniser for the
// asynchronous rx line and a rising-edge detector on the registered
// oversample clock baud_in. baud_in is only ever sampled as data.
`timescale 1ns/1ps

module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic SystemClk,
    input  logic rst_n,
    input  logic baud_in,
    input  logic rx,
    output logic rx_s,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   baud_q;

    // Shift rx through the synchroniser chain and keep a one-cycle copy of baud_in.
    always_ff @(posedge SystemClk or negedge rst_n) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of its neighbour; blocking would collapse the chain.
        if (!rst_n) begin
            sync_q <= '1;
            baud_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            baud_q <= baud_in;
        end
    end

    // Oldest stage is the clean line; tick is one SystemClk wide per baud_in rise.
    assign rx_s = sync_q[SYNC_STAGES-1];
    assign tick = baud_in & ~baud_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Oversamples the synchronised rx line on baud_in ticks,
// locates the start-bit centre, samples each data bit and the stop bit at
// mid-bit, and hands completed bytes over through a valid/ack flag with
// frame-error and overrun pulses.
`timescale 1ns/1ps

module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 SystemClk,
    input  logic                 rst_n,
    input  logic                 baud_in,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    // Start bit is confirmed half a bit after its edge; data and stop bits
    // are then sampled a full bit apart, which lands each on its centre.
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(mid_tick(OVERSAMPLE));
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 tick;

    uart_state_e          state,    state_n;
    logic [TICK_W-1:0]    tick_cnt, tick_cnt_n;
    logic [BIT_W-1:0]     bit_idx,  bit_idx_n;
    logic [DATA_BITS-1:0] shreg,    shreg_n;

    // Decisions taken on the stop-bit sample, registered into the outputs.
    logic                 load_byte;
    logic                 stop_err;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .SystemClk (SystemClk),
        .rst_n     (rst_n),
        .baud_in   (baud_in),
        .rx        (rx),
        .rx_s      (rx_s),
        .tick      (tick)
    );

    // Frame state, oversample counter, bit index and shift register.
    always_ff @(posedge SystemClk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
        end
    end

    // Next-state logic: everything advances only on a baud tick.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        load_byte  = 1'b0;
        stop_err   = 1'b0;

        if (tick) begin
            unique case (state)
                IDLE: begin
                    // First tick that sees the line low starts a frame, so
                    // a start bit right after the previous stop is accepted.
                    if (!rx_s) begin
                        state_n    = START;
                        tick_cnt_n = '0;
                    end
                end

                START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_cnt_n = '0;
                        if (!rx_s) begin
                            state_n   = DATA;
                            bit_idx_n = '0;
                        end else begin
                            // Line went back high before mid-start: a glitch.
                            state_n = IDLE;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_n = '0;
                        shreg_n    = {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_idx == BIT_LAST) begin
                            state_n = STOP;
                        end else begin
                            bit_idx_n = bit_idx + 1'b1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_n = '0;
                        state_n    = IDLE;
                        if (rx_s) begin
                            load_byte = 1'b1;
                        end else begin
                            stop_err = 1'b1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end

                default: begin
                    state_n    = IDLE;
                    tick_cnt_n = '0;
                end
            endcase
        end
    end

    // Consumer handshake: load on a good stop bit, clear on ack, flag overrun
    // only when an unread byte is overwritten without a same-cycle ack.
    always_ff @(posedge SystemClk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_err;
            overrun   <= load_byte & rx_valid & ~rx_ack;
            if (load_byte) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Any frame in progress counts as busy.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: reset mid-frame, single bytes, glitch reject,
// framing error, overrun with and without a same-cycle ack, and skewed bit
// rates on a slower baud source.
`timescale 1ns/1ps

module tb_uart_rx;

    logic       SystemClk = 1'b0;
    logic       rst_n;
    logic       baud_in;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx dut (
        .SystemClk (SystemClk),
        .rst_n     (rst_n),
        .baud_in   (baud_in),
        .rx        (rx),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 SystemClk = ~SystemClk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Baud source: square wave with baud_half SystemClk cycles per half period.
    int baud_half     = 3;
    int hcnt          = 0;
    int cyc           = 0;
    int tick_num      = 0;
    int last_rise_cyc = -100;

    initial begin
        baud_in = 1'b0;
        forever begin
            @(posedge SystemClk);
            #1;
            cyc++;
            hcnt++;
            if (hcnt >= baud_half) begin
                hcnt    = 0;
                baud_in = ~baud_in;
                if (baud_in) begin
                    tick_num++;
                    last_rise_cyc = cyc;
                end
            end
        end
    end

    // Pulse counters and valid-latency check, sampled on the falling edge.
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   vr_cnt = 0;
    logic prev_valid = 1'b0;

    initial begin
        forever begin
            @(negedge SystemClk);
            if (frame_err === 1'b1) fe_cnt++;
            if (overrun === 1'b1)   ov_cnt++;
            if (rx_valid === 1'b1 && prev_valid === 1'b0) begin
                vr_cnt++;
                check("valid_latency", cyc - last_rise_cyc, 1);
            end
            prev_valid = rx_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // All stimulus is applied 2 ns after a rising edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge SystemClk);
            #2;
        end
    endtask

    // Return in the cycle where baud_in has just risen.
    task automatic align();
        int t0 = tick_num;
        int waited = 0;
        while (tick_num == t0 && waited < 4 * baud_half + 8) begin
            cycles(1);
            waited++;
        end
        if (tick_num == t0) check("align_timeout", 1, 0);
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        cycles(n);
    endtask

    task automatic send_bits(input logic [7:0] d, input logic stop_bit, input int n);
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(d[i], n);
        drive_bit(stop_bit, n);
        rx = 1'b1;
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        cycles(1);
        rx_ack = 1'b0;
    endtask

    // Raise rx_ack in the cycle of the given tick number.
    task automatic ack_on_tick(input int target);
        int waited = 0;
        while (tick_num < target && waited < 4000) begin
            cycles(1);
            waited++;
        end
        if (tick_num < target) check("ack_tick_timeout", 1, 0);
        ack();
    endtask

    localparam int BIT = 96;  // 16 ticks of 6 cycles at baud_half = 3

    logic [7:0] singles [2] = '{8'h55, 8'hA5};
    logic [7:0] skew_d  [4] = '{8'hC3, 8'h5A, 8'h01, 8'h80};
    int         skew_n  [4] = '{627, 653, 627, 653};

    initial begin
        int t;
        rst_n  = 1'b0;
        rx     = 1'b1;
        rx_ack = 1'b0;

        @(negedge SystemClk);
        check("por_rx_data",   rx_data,   8'h00);
        check("por_rx_valid",  rx_valid,  1'b0);
        check("por_frame_err", frame_err, 1'b0);
        check("por_overrun",   overrun,   1'b0);
        check("por_busy",      busy,      1'b0);
        @(posedge SystemClk);
        #2;
        rst_n = 1'b1;
        cycles(10);

        // Reset during the data bits of 0xA5 (1,0,1 sent), then 0x3C.
        align();
        drive_bit(1'b0, BIT);
        drive_bit(1'b1, BIT);
        drive_bit(1'b0, BIT);
        drive_bit(1'b1, BIT);
        cycles(BIT / 2);
        check("busy_before_reset", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge SystemClk);
        check("rst_busy",     busy,     1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        rx = 1'b1;
        cycles(4);
        rst_n = 1'b1;
        cycles(BIT * 2);
        check("rst_no_valid", vr_cnt, 0);
        align();
        send_bits(8'h3C, 1'b1, BIT);
        check("after_rst_data",  rx_data,  8'h3C);
        check("after_rst_valid", rx_valid, 1'b1);
        check("after_rst_ferr",  fe_cnt,   0);
        ack();
        cycles(2);

        // Single bytes with ack after each.
        for (int i = 0; i < 2; i++) begin
            align();
            fork
                send_bits(singles[i], 1'b1, BIT);
                begin
                    cycles(BIT * 5);
                    check("busy_mid_frame", busy, 1'b1);
                end
            join
            check("single_data",  rx_data,  {24'h0, singles[i]});
            check("single_valid", rx_valid, 1'b1);
            check("single_busy",  busy,     1'b0);
            ack();
            cycles(1);
            check("single_acked", rx_valid, 1'b0);
        end

        // Glitch: low for 4 ticks only.
        align();
        rx = 1'b0;
        cycles(4 * 2 * baud_half);
        check("glitch_busy", busy, 1'b1);
        rx = 1'b1;
        cycles(20 * 2 * baud_half);
        check("glitch_idle",  busy,     1'b0);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_ferr",  fe_cnt,   0);

        // Framing error: 0xFF with a low stop bit.
        align();
        send_bits(8'hFF, 1'b0, BIT);
        cycles(30 * 2 * baud_half);
        check("frame_err_count", fe_cnt,   1);
        check("frame_valid",     rx_valid, 1'b0);
        check("frame_keep_data", rx_data,  8'hA5);
        check("frame_idle",      busy,     1'b0);

        // Overrun: two bytes without ack.
        align();
        send_bits(8'h12, 1'b1, BIT);
        align();
        send_bits(8'h34, 1'b1, BIT);
        check("overrun_count", ov_cnt,   1);
        check("overrun_data",  rx_data,  8'h34);
        check("overrun_valid", rx_valid, 1'b1);
        ack();
        cycles(2);

        // Ack on the completion cycle of the second byte: no overrun.
        align();
        send_bits(8'h56, 1'b1, BIT);
        align();
        t = tick_num;
        fork
            send_bits(8'h78, 1'b1, BIT);
            ack_on_tick(t + 153);
        join
        check("ack_same_cycle_ov",    ov_cnt,   1);
        check("ack_same_cycle_valid", rx_valid, 1'b1);
        check("ack_same_cycle_data",  rx_data,  8'h78);
        ack();
        cycles(2);

        // Slower baud source, bit periods skewed by -2% / +2% from 640 cycles.
        baud_half = 20;
        cycles(100);
        for (int i = 0; i < 4; i++) begin
            align();
            send_bits(skew_d[i], 1'b1, skew_n[i]);
            check("skew_data",  rx_data,  {24'h0, skew_d[i]});
            check("skew_valid", rx_valid, 1'b1);
            ack();
            cycles(2);
        end

        check("total_valid_rises", vr_cnt, 9);
        check("total_frame_errs",  fe_cnt, 1);
        check("total_overruns",    ov_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
